serial_comparator: RTL and testbench

Parametrised, sequential magnitude comparator: the successor to our fixed-width combinational comparator. It compares two WIDTH-bit operands MSB-first, one bit per clock, with early exit at the first differing bit. Unsigned and two's-complement modes are supported. A start/busy/done handshake lets a controller or FSM issue back-to-back comparisons. It produces the same one-hot greater/equal/less result as the combinational block, registered and held until the next comparison.

---
 rtl/serial_comparator.sv | 76 +++++++
 tb/tb_serial_comparator.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/serial_comparator.sv
// serial_comparator: MSB-first bit-serial magnitude compare with early exit and start/busy/done handshake
// Ports: clock, reset_n (sync, active-low); start, a, b sampled when ready (IDLE/DONE);
//        busy high during COMPARE; done one-cycle pulse; gt/eq/lt one-hot result held until next start
module serial_comparator #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);
    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] TOP = IW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] ra, rb, ra_nx, rb_nx;
    logic [IW-1:0] idx, idx_nx;
    logic [2:0] res, res_nx;
    logic diff, flip;
    always_comb begin
        state_nx = state;
        ra_nx    = ra;
        rb_nx    = rb;
        idx_nx   = idx;
        res_nx   = res;
        diff     = ra[idx] ^ rb[idx];
        // the sign bit carries inverted weight in two's complement
        flip     = SIGNED && (idx == TOP);
        if (state != COMPARE && start) begin
            ra_nx    = a;
            rb_nx    = b;
            idx_nx   = TOP;
            res_nx   = 3'b000;
            state_nx = COMPARE;
        end else if (state == COMPARE) begin
            if (diff) begin
                res_nx   = (ra[idx] ^ flip) ? 3'b100 : 3'b001;
                state_nx = DONE;
            end else if (idx == '0) begin
                res_nx   = 3'b010;
                state_nx = DONE;
            end else begin
                idx_nx = idx - 1'b1;
            end
        end else if (state == DONE) begin
            state_nx = IDLE;
        end
    end
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            idx   <= TOP;
            res   <= 3'b000;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            ra    <= ra_nx;
            rb    <= rb_nx;
            idx   <= idx_nx;
            res   <= res_nx;
            busy  <= (state_nx == COMPARE);
            done  <= (state_nx == DONE);
        end
    end
    assign {gt, eq, lt} = res;
endmodule

// File: tb/tb_serial_comparator.sv
// tb_serial_comparator: directed and exhaustive checks of serial_comparator in unsigned and signed modes
module tb_serial_comparator;
    logic clock = 1'b0, reset_n = 1'b0, start = 1'b0, start4 = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic [3:0] a4 = '0, b4 = '0;
    logic busy_u, done_u, gt_u, eq_u, lt_u;
    logic busy_s, done_s, gt_s, eq_s, lt_s;
    logic busy_u4, done_u4, gt_u4, eq_u4, lt_u4;
    logic busy_s4, done_s4, gt_s4, eq_s4, lt_s4;
    int errors = 0, checks = 0;

    serial_comparator #(.WIDTH(8), .SIGNED(1'b0)) u8 (.clock(clock), .reset_n(reset_n), .start(start), .a(a), .b(b),
        .busy(busy_u), .done(done_u), .gt(gt_u), .eq(eq_u), .lt(lt_u));
    serial_comparator #(.WIDTH(8), .SIGNED(1'b1)) s8 (.clock(clock), .reset_n(reset_n), .start(start), .a(a), .b(b),
        .busy(busy_s), .done(done_s), .gt(gt_s), .eq(eq_s), .lt(lt_s));
    serial_comparator #(.WIDTH(4), .SIGNED(1'b0)) u4 (.clock(clock), .reset_n(reset_n), .start(start4), .a(a4), .b(b4),
        .busy(busy_u4), .done(done_u4), .gt(gt_u4), .eq(eq_u4), .lt(lt_u4));
    serial_comparator #(.WIDTH(4), .SIGNED(1'b1)) s4 (.clock(clock), .reset_n(reset_n), .start(start4), .a(a4), .b(b4),
        .busy(busy_s4), .done(done_s4), .gt(gt_s4), .eq(eq_s4), .lt(lt_s4));

    always #5 clock = ~clock;

    function automatic logic [31:0] ou();  return 32'({busy_u, done_u, gt_u, eq_u, lt_u}); endfunction
    function automatic logic [31:0] os();  return 32'({busy_s, done_s, gt_s, eq_s, lt_s}); endfunction
    function automatic logic [31:0] ou4(); return 32'({busy_u4, done_u4, gt_u4, eq_u4, lt_u4}); endfunction
    function automatic logic [31:0] os4(); return 32'({busy_s4, done_s4, gt_s4, eq_s4, lt_s4}); endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic cmp8(input string tag, input logic [7:0] va, input logic [7:0] vb, input logic [2:0] ru,
                        input logic [2:0] rs, input int lu, input int ls, input bit disturb);
        int nu, ns;
        logic [2:0] gu, gs;
        nu = 0; ns = 0; gu = '0; gs = '0;
        a = va; b = vb; start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, " accept u"}, ou(), 32'h10);
        chk({tag, " accept s"}, os(), 32'h10);
        for (int n = 1; n <= 20 && (nu == 0 || ns == 0); n++) begin
            if (disturb && n == 2) begin start = 1'b1; a = ~va; b = ~vb; end
            if (disturb && n == 3) start = 1'b0;
            step();
            chk({tag, " excl"}, 32'((busy_u & done_u) | (busy_s & done_s)), 32'h0);
            if (done_u && nu == 0) begin nu = n; gu = {gt_u, eq_u, lt_u}; end
            if (done_s && ns == 0) begin ns = n; gs = {gt_s, eq_s, lt_s}; end
        end
        start = 1'b0;
        chk({tag, " lat u"}, 32'(nu), 32'(lu));
        chk({tag, " res u"}, 32'(gu), 32'(ru));
        chk({tag, " lat s"}, 32'(ns), 32'(ls));
        chk({tag, " res s"}, 32'(gs), 32'(rs));
        step();
        step();
        chk({tag, " hold u"}, ou(), 32'(ru));
        chk({tag, " hold s"}, os(), 32'(rs));
    endtask

    task automatic exhaustive4();
        logic [3:0] va, vb;
        logic [2:0] eu, es, gu, gs;
        int lat, nu, ns;
        for (int i = 0; i < 256; i++) begin
            va = 4'(i >> 4);
            vb = 4'(i);
            lat = 4;
            for (int k = 0; k < 4; k++) if (va[k] != vb[k]) lat = 4 - k;
            eu = (va > vb) ? 3'b100 : (va == vb) ? 3'b010 : 3'b001;
            es = ($signed(va) > $signed(vb)) ? 3'b100 : (va == vb) ? 3'b010 : 3'b001;
            nu = 0; ns = 0; gu = '0; gs = '0;
            a4 = va; b4 = vb; start4 = 1'b1;
            step();
            start4 = 1'b0;
            for (int n = 1; n <= 10 && (nu == 0 || ns == 0); n++) begin
                step();
                if (done_u4 && nu == 0) begin nu = n; gu = {gt_u4, eq_u4, lt_u4}; end
                if (done_s4 && ns == 0) begin ns = n; gs = {gt_s4, eq_s4, lt_s4}; end
            end
            chk($sformatf("x4u res a=%h b=%h", va, vb), 32'(gu), 32'(eu));
            chk($sformatf("x4u lat a=%h b=%h", va, vb), 32'(nu), 32'(lat));
            chk($sformatf("x4s res a=%h b=%h", va, vb), 32'(gs), 32'(es));
            chk($sformatf("x4s lat a=%h b=%h", va, vb), 32'(ns), 32'(lat));
        end
    endtask

    initial begin
        int pulses, t1, t2;
        logic [2:0] r1, r2;
        step();
        step();
        reset_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            step();
            chk("idle u", ou(), 32'h0);
            chk("idle s", os(), 32'h0);
            chk("idle u4", ou4(), 32'h0);
            chk("idle s4", os4(), 32'h0);
        end

        a = 8'h55; b = 8'h55; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("midreset u", ou(), 32'h0);
        chk("midreset s", os(), 32'h0);
        pulses = 0;
        for (int n = 0; n < 10; n++) begin
            step();
            pulses += int'(done_u) + int'(done_s) + int'(busy_u) + int'(busy_s);
        end
        chk("midreset quiet", 32'(pulses), 32'h0);

        cmp8("80v7F", 8'h80, 8'h7F, 3'b100, 3'b001, 1, 1, 1'b0);
        cmp8("3Cv3D", 8'h3C, 8'h3D, 3'b001, 3'b001, 8, 8, 1'b0);
        cmp8("A5vA5", 8'hA5, 8'hA5, 3'b010, 3'b010, 8, 8, 1'b0);
        cmp8("80v01", 8'h80, 8'h01, 3'b100, 3'b001, 1, 1, 1'b0);
        cmp8("FFvFE", 8'hFF, 8'hFE, 3'b100, 3'b100, 8, 8, 1'b0);
        cmp8("7Fv80", 8'h7F, 8'h80, 3'b001, 3'b100, 1, 1, 1'b0);
        cmp8("ignore", 8'h3C, 8'h3D, 3'b001, 3'b001, 8, 8, 1'b1);

        t1 = 0; t2 = 0; r1 = '0; r2 = '0;
        a = 8'h01; b = 8'h00; start = 1'b1;
        step();
        for (int n = 1; n <= 30 && t2 == 0; n++) begin
            step();
            chk("b2b busy", 32'(busy_u), 32'(!done_u));
            if (busy_u) chk("b2b clear", 32'({gt_u, eq_u, lt_u}), 32'h0);
            if (done_u) begin
                if (t1 == 0) begin t1 = n; r1 = {gt_u, eq_u, lt_u}; a = 8'h00; b = 8'h00; end
                else begin t2 = n; r2 = {gt_u, eq_u, lt_u}; start = 1'b0; end
            end
        end
        start = 1'b0;
        chk("b2b t1", 32'(t1), 32'd8);
        chk("b2b r1", 32'(r1), 32'h4);
        chk("b2b t2", 32'(t2), 32'd17);
        chk("b2b r2", 32'(r2), 32'h2);
        step();
        step();
        chk("b2b end", ou(), 32'h2);

        exhaustive4();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
